// File: rtl/spi_receptor.sv
// -----------------------------------------------------------------------------
// spi_receptor
//
// SPI slave on the system clock. The master's SCK, CS and MOSI are
// oversampled on CLK and edge-detected. The block shifts in a WIDTH-bit word
// from MOSI and shifts out a WIDTH-bit word on MISO, MSB first, in any of the
// four CKP/CPH modes. Each complete received word is presented on o_rx_data
// with a one-cycle o_rx_valid strobe. If CS rises before the frame is
// complete, o_frame_err pulses for one cycle.
//
// Build option:
//   SPI_RX_SYNC_EN  defined   : SCK, CS and MOSI each pass through a 2-FF
//                               synchronizer before edge detection, which
//                               adds 2 CLK to every latency. SCK levels must
//                               then be held for at least 2 CLK.
//                   undefined : SCK, CS and MOSI are used directly and must be
//                               synchronous to CLK.
//
// Ports:
//   CLK          in   system clock, rising edge
//   RESET        in   synchronous reset, active low
//   i_sck        in   serial clock from master (each level held >= 1 CLK)
//   i_cs         in   chip select, active low
//   i_mosi       in   serial data from master, MSB first
//   i_ckp        in   clock polarity (idle level of SCK)
//   i_cph        in   clock phase (0: sample on leading edge, 1: trailing)
//   i_tx_data    in   word returned to the master, latched at CS fall
//   o_miso       out  serial data to master, MSB first
//   o_rx_data    out  last complete received word
//   o_rx_valid   out  one-cycle pulse when o_rx_data updates
//   o_frame_err  out  one-cycle pulse when CS rises mid-frame
//   o_busy       out  high while a frame is in progress or CS is still low
//
// state   | meaning
// --------+-------------------------------------------------------------------
// IDLE    | CS high; MISO driven 0; waiting for CS to fall
// ACTIVE  | frame in progress; sampling MOSI and shifting MISO on SCK edges
// WAIT_CS | word complete; further SCK edges ignored until CS rises
// -----------------------------------------------------------------------------
module spi_receptor #(
   parameter int WIDTH = 16
) (
   input  logic             CLK,
   input  logic             RESET,
   input  logic             i_sck,
   input  logic             i_cs,
   input  logic             i_mosi,
   input  logic             i_ckp,
   input  logic             i_cph,
   input  logic [WIDTH-1:0] i_tx_data,
   output logic             o_miso,
   output logic [WIDTH-1:0] o_rx_data,
   output logic             o_rx_valid,
   output logic             o_frame_err,
   output logic             o_busy
);

   localparam int CW = $clog2(WIDTH) + 1;

   typedef enum logic [1:0] {
      IDLE    = 2'd0,
      ACTIVE  = 2'd1,
      WAIT_CS = 2'd2
   } state_t;

   state_t r_state;
   state_t w_state_next;

   logic w_sck;
   logic w_cs;
   logic w_mosi;

   // -------------------------------------------------------------------------
   // Input conditioning
   // -------------------------------------------------------------------------
`ifdef SPI_RX_SYNC_EN
   logic [1:0] r_sck_sync;
   logic [1:0] r_cs_sync;
   logic [1:0] r_mosi_sync;

   // SCK stages reset to the idle polarity so releasing reset never looks
   // like an SCK edge; CS stages reset to the deasserted level.
   always_ff @(posedge CLK) begin
      if (!RESET) begin
         r_sck_sync  <= {2{i_ckp}};
         r_cs_sync   <= 2'b11;
         r_mosi_sync <= 2'b00;
      end else begin
         r_sck_sync  <= {r_sck_sync[0], i_sck};
         r_cs_sync   <= {r_cs_sync[0], i_cs};
         r_mosi_sync <= {r_mosi_sync[0], i_mosi};
      end
   end

   assign w_sck  = r_sck_sync[1];
   assign w_cs   = r_cs_sync[1];
   assign w_mosi = r_mosi_sync[1];
`else
   assign w_sck  = i_sck;
   assign w_cs   = i_cs;
   assign w_mosi = i_mosi;
`endif

   // -------------------------------------------------------------------------
   // Edge detection
   // -------------------------------------------------------------------------
   logic r_sck_d;
   logic r_cs_d;

   always_ff @(posedge CLK) begin
      if (!RESET) begin
         r_sck_d <= i_ckp;
         r_cs_d  <= 1'b1;
      end else begin
         r_sck_d <= w_sck;
         r_cs_d  <= w_cs;
      end
   end

   logic w_sck_rise;
   logic w_sck_fall;
   logic w_cs_rise;
   logic w_cs_fall;

   assign w_sck_rise =  w_sck & ~r_sck_d;
   assign w_sck_fall = ~w_sck &  r_sck_d;
   assign w_cs_rise  =  w_cs  & ~r_cs_d;
   assign w_cs_fall  = ~w_cs  &  r_cs_d;

   // -------------------------------------------------------------------------
   // Mode decode (uses the mode latched at the start of the frame)
   // -------------------------------------------------------------------------
   logic r_ckp;
   logic r_cph;
   logic w_lead;
   logic w_trail;
   logic w_sample_edge;
   logic w_shift_edge;

   assign w_lead        = r_ckp ? w_sck_fall : w_sck_rise;
   assign w_trail       = r_ckp ? w_sck_rise : w_sck_fall;
   assign w_sample_edge = r_cph ? w_trail : w_lead;
   assign w_shift_edge  = r_cph ? w_lead  : w_trail;

   // -------------------------------------------------------------------------
   // Datapath registers
   // -------------------------------------------------------------------------
   logic [WIDTH-1:0] r_tx_shift;
   // Only the first WIDTH-1 bits need storing; the last bit is taken straight
   // from MOSI when the word completes.
   logic [WIDTH-2:0] r_rx_shift;
   logic [CW-1:0]    r_bit_cnt;
   logic             r_first;
   logic [WIDTH-1:0] r_rx_data;
   logic             r_rx_valid;
   logic             r_frame_err;

   logic [WIDTH-1:0] w_rx_next;
   assign w_rx_next = {r_rx_shift, w_mosi};

   // -------------------------------------------------------------------------
   // FSM: state register
   // -------------------------------------------------------------------------
   always_ff @(posedge CLK) begin
      if (!RESET) begin
         r_state <= IDLE;
      end else begin
         r_state <= w_state_next;
      end
   end

   // -------------------------------------------------------------------------
   // FSM: next state and datapath controls
   // -------------------------------------------------------------------------
   logic w_load;
   logic w_do_sample;
   logic w_do_shift;
   logic w_clr_first;
   logic w_done;
   logic w_err;

   always_comb begin
      w_state_next = r_state;
      w_load       = 1'b0;
      w_do_sample  = 1'b0;
      w_do_shift   = 1'b0;
      w_clr_first  = 1'b0;
      w_done       = 1'b0;
      w_err        = 1'b0;

      case (r_state)
         IDLE: begin
            if (w_cs_fall) begin
               w_load       = 1'b1;
               w_state_next = ACTIVE;
            end
         end

         ACTIVE: begin
            w_do_sample = w_sample_edge;

            // In CPH=1 the MSB is already on MISO when CS falls, so the very
            // first leading edge must leave it in place for the master.
            if (w_shift_edge) begin
               if (r_cph && r_first) begin
                  w_clr_first = 1'b1;
               end else begin
                  w_do_shift = 1'b1;
               end
            end

            // A final sample coinciding with CS rise still completes the
            // word; CS is already high, so return straight to IDLE.
            if (w_sample_edge && (r_bit_cnt == CW'(WIDTH - 1))) begin
               w_done       = 1'b1;
               w_state_next = w_cs_rise ? IDLE : WAIT_CS;
            end else if (w_cs_rise) begin
               w_err        = 1'b1;
               w_state_next = IDLE;
            end
         end

         WAIT_CS: begin
            if (w_cs_rise) begin
               w_state_next = IDLE;
            end
         end

         default: begin
            w_state_next = IDLE;
         end
      endcase
   end

   // -------------------------------------------------------------------------
   // Datapath
   // -------------------------------------------------------------------------
   always_ff @(posedge CLK) begin
      if (!RESET) begin
         r_tx_shift  <= '0;
         r_rx_shift  <= '0;
         r_bit_cnt   <= '0;
         r_first     <= 1'b0;
         r_ckp       <= 1'b0;
         r_cph       <= 1'b0;
         r_rx_data   <= '0;
         r_rx_valid  <= 1'b0;
         r_frame_err <= 1'b0;
      end else begin
         r_rx_valid  <= w_done;
         r_frame_err <= w_err;

         if (w_load) begin
            r_tx_shift <= i_tx_data;
            r_rx_shift <= '0;
            r_bit_cnt  <= '0;
            r_first    <= 1'b1;
            r_ckp      <= i_ckp;
            r_cph      <= i_cph;
         end else begin
            if (w_do_sample) begin
               r_rx_shift <= w_rx_next[WIDTH-2:0];
               r_bit_cnt  <= r_bit_cnt + CW'(1);
            end
            if (w_do_shift) begin
               r_tx_shift <= {r_tx_shift[WIDTH-2:0], 1'b0};
            end
            if (w_clr_first) begin
               r_first <= 1'b0;
            end
         end

         if (w_done) begin
            r_rx_data <= w_rx_next;
         end
      end
   end

   // -------------------------------------------------------------------------
   // Outputs
   // -------------------------------------------------------------------------
   assign o_miso      = (r_state == ACTIVE) & r_tx_shift[WIDTH-1];
   assign o_busy      = (r_state != IDLE);
   assign o_rx_data   = r_rx_data;
   assign o_rx_valid  = r_rx_valid;
   assign o_frame_err = r_frame_err;

endmodule

// File: tb/tb_spi_receptor.sv
module tb_spi_receptor;

   logic        CLK;
   logic        RESET;
   logic        i_sck;
   logic        i_cs;
   logic        i_mosi;
   logic        i_ckp;
   logic        i_cph;
   logic [15:0] i_tx_data;
   logic        o_miso;
   logic [15:0] o_rx_data;
   logic        o_rx_valid;
   logic        o_frame_err;
   logic        o_busy;

   spi_receptor #(.WIDTH(16)) dut (
      .CLK         (CLK),
      .RESET       (RESET),
      .i_sck       (i_sck),
      .i_cs        (i_cs),
      .i_mosi      (i_mosi),
      .i_ckp       (i_ckp),
      .i_cph       (i_cph),
      .i_tx_data   (i_tx_data),
      .o_miso      (o_miso),
      .o_rx_data   (o_rx_data),
      .o_rx_valid  (o_rx_valid),
      .o_frame_err (o_frame_err),
      .o_busy      (o_busy)
   );

   initial CLK = 1'b0;
   always #5 CLK = ~CLK;

   int n_pass  = 0;
   int n_total = 0;

   // Expected output events: a complete word or an aborted frame.
   typedef struct {
      bit          is_err;
      logic [15:0] data;
   } ev_t;

   ev_t         exp_q[$];
   logic [15:0] last_word = 16'h0000;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_total++;
      if (act === exp) n_pass++;
      else $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
   endtask

   // Monitor: every output pulse must match the next expected event.
   always @(negedge CLK) begin
      if (o_rx_valid || o_frame_err) begin
         if (exp_q.size() == 0) begin
            check("unexpected_event", {30'd0, o_rx_valid, o_frame_err}, 32'd0);
         end else begin
            ev_t e;
            e = exp_q.pop_front();
            check("event_is_err", {31'd0, o_frame_err}, {31'd0, e.is_err});
            check("event_is_valid", {31'd0, o_rx_valid}, {31'd0, !e.is_err});
            if (!e.is_err) begin
               check("rx_data", {16'd0, o_rx_data}, {16'd0, e.data});
               last_word = e.data;
            end else begin
               check("rx_data_held", {16'd0, o_rx_data}, {16'd0, last_word});
            end
         end
      end
   end

   // Master model. Sends nbits clocks; bits beyond 16 carry random data.
   // cs_last raises CS together with the final sample edge.
   // do_reset ends the frame with a reset pulse instead of a CS rise.
   task automatic spi_frame(input bit ckp, input bit cph, input logic [15:0] tx,
                            input logic [15:0] mo, input int nbits, input int hmax,
                            input int pre, input int post, input bit cs_last,
                            input bit do_reset, input bit scramble);
      logic [15:0] cap;
      int h;
      cap = 16'h0000;
      i_ckp = ckp;
      i_cph = cph;
      i_tx_data = tx;
      i_sck = ckp;
      repeat (pre) @(negedge CLK);
      i_cs = 1'b0;
      if (!do_reset) begin
         if (nbits >= 16) exp_q.push_back('{1'b0, mo});
         else exp_q.push_back('{1'b1, 16'h0000});
      end
      @(negedge CLK);
      check("busy_active", {31'd0, o_busy}, 32'd1);
      check("miso_first", {31'd0, o_miso}, {31'd0, tx[15]});
      if (scramble) begin
         i_ckp = 1'($urandom);
         i_cph = 1'($urandom);
         i_tx_data = 16'($urandom);
      end
      @(negedge CLK);
      for (int i = 0; i < nbits; i++) begin
         logic b;
         bit last;
         b = (i < 16) ? mo[15-i] : 1'($urandom);
         last = cs_last && (i == nbits - 1);
         h = $urandom_range(1, hmax);
         if (!cph) begin
            i_mosi = b;
            repeat (h) @(negedge CLK);
            if (i < 16) cap[15-i] = o_miso;
            i_sck = ~ckp;
            if (last) i_cs = 1'b1;
            repeat (h) @(negedge CLK);
            if (!last) begin
               i_sck = ckp;
               repeat (h) @(negedge CLK);
            end
         end else begin
            i_sck = ~ckp;
            i_mosi = b;
            repeat (h) @(negedge CLK);
            if (i < 16) cap[15-i] = o_miso;
            i_sck = ckp;
            if (last) i_cs = 1'b1;
            repeat (h) @(negedge CLK);
         end
      end
      if (nbits >= 16) check("miso_word", {16'd0, cap}, {16'd0, tx});
      if (nbits >= 16 && !cs_last && !do_reset) begin
         check("busy_wait_cs", {31'd0, o_busy}, 32'd1);
         check("miso_wait_cs", {31'd0, o_miso}, 32'd0);
      end
      if (do_reset) begin
         RESET = 1'b0;
         i_cs = 1'b1;
         @(negedge CLK);
         check("rst_rx_data", {16'd0, o_rx_data}, 32'd0);
         check("rst_rx_valid", {31'd0, o_rx_valid}, 32'd0);
         check("rst_frame_err", {31'd0, o_frame_err}, 32'd0);
         check("rst_busy", {31'd0, o_busy}, 32'd0);
         check("rst_miso", {31'd0, o_miso}, 32'd0);
         last_word = 16'h0000;
         RESET = 1'b1;
         i_sck = ckp;
         repeat (post) @(negedge CLK);
      end else begin
         i_cs = 1'b1;
         @(negedge CLK);
         check("busy_idle", {31'd0, o_busy}, 32'd0);
         i_sck = ckp;
         repeat (post - 1) @(negedge CLK);
      end
   endtask

   initial begin
      RESET = 1'b0;
      i_cs = 1'b1;
      i_sck = 1'b1;
      i_ckp = 1'b1;
      i_cph = 1'b0;
      i_mosi = 1'b0;
      i_tx_data = 16'h0000;
      repeat (3) @(negedge CLK);
      check("reset_miso", {31'd0, o_miso}, 32'd0);
      check("reset_rx_data", {16'd0, o_rx_data}, 32'd0);
      check("reset_rx_valid", {31'd0, o_rx_valid}, 32'd0);
      check("reset_frame_err", {31'd0, o_frame_err}, 32'd0);
      check("reset_busy", {31'd0, o_busy}, 32'd0);
      RESET = 1'b1;
      repeat (2) @(negedge CLK);

      // All four modes with the reference words.
      for (int m = 0; m < 4; m++) begin
         spi_frame(1'(m >> 1), 1'(m & 1), 16'hA5C3, 16'h3C5A, 16, 2, 3, 2, 0, 0, 0);
      end
      // Extra master clocks land in WAIT_CS.
      spi_frame(0, 0, 16'hA5C3, 16'h3C5A, 18, 2, 3, 2, 0, 0, 0);
      spi_frame(1, 1, 16'h1234, 16'h3C5A, 18, 2, 3, 2, 0, 0, 0);
      // Aborted frames, then a good frame.
      spi_frame(0, 0, 16'hA5C3, 16'h1111, 7, 2, 3, 2, 0, 0, 0);
      spi_frame(0, 1, 16'hA5C3, 16'h2222, 0, 2, 3, 2, 0, 0, 0);
      spi_frame(0, 0, 16'h5A5A, 16'hBEEF, 16, 2, 3, 2, 0, 0, 0);
      // Reset mid-frame, then an all-ones word.
      spi_frame(1, 0, 16'hA5C3, 16'h3C5A, 9, 2, 3, 2, 0, 1, 0);
      spi_frame(0, 0, 16'hA5C3, 16'hFFFF, 16, 2, 3, 2, 0, 0, 0);
      // Back-to-back frames with CS high for one cycle.
      spi_frame(0, 0, 16'h0F0F, 16'h0001, 16, 1, 3, 1, 0, 0, 0);
      spi_frame(0, 0, 16'hF0F0, 16'h8000, 16, 1, 0, 2, 0, 0, 0);
      // CS rise in the same cycle as the final sample edge.
      spi_frame(0, 0, 16'hC001, 16'h6BD2, 16, 2, 3, 2, 1, 0, 0);
      spi_frame(1, 1, 16'h8003, 16'h94E7, 16, 2, 3, 2, 1, 0, 0);

      // Randomized frames; mode pins and tx_data are disturbed mid-frame.
      for (int k = 0; k < 40; k++) begin
         int sel;
         int nb;
         bit csl;
         sel = $urandom_range(0, 9);
         csl = 1'b0;
         if (sel < 6) nb = 16;
         else if (sel == 6) nb = 17;
         else if (sel == 7) nb = 18;
         else if (sel == 8) nb = $urandom_range(0, 15);
         else begin
            nb = 16;
            csl = 1'b1;
         end
         spi_frame(1'($urandom), 1'($urandom), 16'($urandom), 16'($urandom), nb, 3,
                   $urandom_range(2, 4), $urandom_range(1, 3), csl, 0, 1);
      end

      repeat (5) @(negedge CLK);
      check("pending_events", exp_q.size(), 32'd0);
      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end

endmodule

// File: doc/spi_receptor.md
# spi_receptor

SPI peripheral (slave) that sits downstream of the CPU-side SPI master on the same CLK. It detects edges of the master's SCK, shifts in a 16-bit word from MOSI and shifts out a 16-bit word on MISO, in any of the four CKP/CPH modes. Received words go to the local logic with a one-cycle valid strobe. Aborted frames are reported.

## Interface
- WIDTH, 16, frame length in bits (≥2).
- CLK  in  1  system clock, rising edge.
- RESET  in  1  synchronous, active-low.
- SCK  in  1  serial clock from master; each level held ≥1 CLK cycle.
- CS  in  1  chip select, active-low.
- MOSI  in  1  serial data from master, MSB first.
- CKP  in  1  clock polarity (idle level of SCK).
- CPH  in  1  clock phase (0: sample on leading edge; 1: sample on trailing edge).
- tx_data  in  WIDTH  word to return; latched at CS falling edge.
- MISO  out  1  serial data to master, MSB first.
- rx_data  out  WIDTH  last complete received word.
- rx_valid  out  1  one-cycle pulse when rx_data updates.
- frame_err  out  1  one-cycle pulse when CS rises mid-frame.
- busy  out  1  high in ACTIVE and WAIT_CS.

## Operation
- Edge detect: sck_d registered each CLK. rise = SCK & ~sck_d; fall = ~SCK & sck_d. CS is handled the same way with cs_d.
- Leading edge = rise if CKP=0, fall if CKP=1. Trailing edge is the opposite.
- Sample edge = leading if CPH=0, trailing if CPH=1.
- CKP/CPH are latched at CS falling edge. Changes mid-frame are ignored.
- FSM states:
  - IDLE: MISO=0, busy=0. On CS fall: tx_shift<=tx_data, rx_shift<=0, bit_cnt<=0, first<=1, latch mode, go ACTIVE.
  - ACTIVE:
    - On sample edge: rx_shift<={rx_shift[WIDTH-2:0],MOSI}, bit_cnt+1.
    - When bit_cnt reaches WIDTH: rx_data<=shifted word, rx_valid=1, go WAIT_CS.
    - Shift edge for CPH=0: trailing edge.
    - Shift edge for CPH=1: leading edge, except the first leading edge of the frame, which clears first and does not shift.
    - On shift edge: tx_shift<={tx_shift[WIDTH-2:0],1'b0}.
    - MISO = tx_shift[WIDTH-1] while CS low.
  - WAIT_CS: all SCK edges ignored; MISO=0. On CS rise go IDLE.
- CS rise in ACTIVE with bit_cnt<WIDTH:
  - frame_err=1 for one cycle, go IDLE.
  - rx_data unchanged, no rx_valid.
  - Applies to bit_cnt=0 too.
- CS rise and the final sample edge in the same cycle: the frame completes (rx_valid), no frame_err.
- bit_cnt is $clog2(WIDTH)+1 bits and does not wrap; extra master clocks (e.g. 18 edges for 16 bits) land in WAIT_CS.

## Timing
- Reset values: MISO=0, rx_data=0, rx_valid=0, frame_err=0, busy=0, state IDLE, sck_d=CKP input, cs_d=1.
- RESET low in any state returns to IDLE next edge; partial frame discarded, no pulses.
- Cycle n is the CLK edge where the edge is detected (registered sck_d ≠ SCK).
- Sample: MOSI sampled at edge n. On the WIDTH-th sample, rx_data and rx_valid are visible in cycle n+1; rx_valid lasts exactly one cycle.
- MISO: updated at edge n for a shift edge detected at n; first bit valid the cycle after CS fall is detected.
- Master constraint: MOSI stable at the CLK edge that detects the sample edge.
- frame_err: visible the cycle after CS rise is detected.

## Configuration
- SPI_RX_SYNC_EN defined:
  - SCK, CS and MOSI each pass through a 2-FF synchronizer before edge detection.
  - All latencies above grow by 2 CLK.
  - SCK levels must be ≥2 CLK.
- SPI_RX_SYNC_EN undefined: inputs are used directly; they must be synchronous to CLK.

## Test plan
- Mode 0 (CKP=0, CPH=0), tx_data=16'hA5C3, master sends 16'h3C5A -> rx_data=16'h3C5A, one rx_valid pulse, master captures 16'hA5C3, frame_err=0.
- Modes 1, 2 and 3 with the same words -> identical results. In mode 1, MISO holds bit 15 through the first leading edge.
- Master issues 18 SCK cycles per frame -> only the first 16 bits used, one rx_valid, busy stays high until CS rises.
- CS rises after 7 bits -> frame_err one-cycle pulse, rx_data keeps previous 16'h3C5A, no rx_valid, next frame receives correctly.
- RESET low after 9 bits -> all outputs at reset values next cycle. Following full frame with 16'hFFFF -> rx_data=16'hFFFF.
- Back-to-back frames 16'h0001 then 16'h8000 with CS high for 1 cycle -> two rx_valid pulses with correct words.
